// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared definitions for the I2C target register bank.
//   state_e          - protocol FSM states
//   RW_READ/RW_WRITE - values of the R/W bit in the address byte
//   ACK_BIT/NACK_BIT - SDA level in the acknowledge slot
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: brings the SDA/SCL pad levels into the clk_i domain and
// derives bus events from them.
//   clk_i, rst_ni  - system clock, async active-low reset
//   sda_i, scl_i   - raw pad levels
//   sda_o          - synchronized SDA level, aligned with the event outputs
//   scl_rise_o     - one-cycle pulse on a synchronized SCL rising edge
//   scl_fall_o     - one-cycle pulse on a synchronized SCL falling edge
//   start_o        - SDA fell while SCL high (START / repeated START)
//   stop_o         - SDA rose while SCL high (STOP)
// Stage [0],[1] form the 2-FF synchronizer, stage [2] is the edge stage;
// events are registered, so a pin change shows up as an event 3 clocks later.
module i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sda_i,
  input  logic scl_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [2:0] sda_q;
  logic [2:0] scl_q;

  // Synchronizer and edge pipeline; idle bus level is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sda_q      <= 3'b111;
      scl_q      <= 3'b111;
      sda_o      <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      sda_q      <= {sda_q[1:0], sda_i};
      scl_q      <= {scl_q[1:0], scl_i};
      sda_o      <= sda_q[1];
      scl_rise_o <= scl_q[1] & ~scl_q[2];
      scl_fall_o <= ~scl_q[1] & scl_q[2];
      start_o    <= scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
      stop_o     <= scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing NUM_REGS 8-bit registers to a bus
// initiator while fabric logic reads/writes them through a local port.
//   clk_clk, reset_reset_n               - clock, async active-low reset
//   i2c_serial_sda_in/scl_in             - pad levels
//   i2c_serial_sda_oe/scl_oe             - 1 pulls the line low (SCL never)
//   reg_wr_en/reg_addr/reg_wr_data       - local write port
//   reg_rd_data                          - combinational read of reg[reg_addr]
//   i2c_wr_strobe/i2c_wr_addr/i2c_wr_data- report of each bus-written byte
//   busy                                 - addressed transaction in progress
// Bus protocol: write = addr(W), pointer byte, data bytes; read = addr(R),
// data bytes from the persistent auto-incrementing pointer.
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         NUM_REGS    = 16,
  parameter int         AW          = $clog2(NUM_REGS)
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          i2c_serial_sda_in,
  input  logic          i2c_serial_scl_in,
  output logic          i2c_serial_sda_oe,
  output logic          i2c_serial_scl_oe,
  input  logic          reg_wr_en,
  input  logic [AW-1:0] reg_addr,
  input  logic [7:0]    reg_wr_data,
  output logic [7:0]    reg_rd_data,
  output logic          i2c_wr_strobe,
  output logic [AW-1:0] i2c_wr_addr,
  output logic [7:0]    i2c_wr_data,
  output logic          busy
);

  logic sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  i2c_sync_edge u_sync (
    .clk_i      (clk_clk),
    .rst_ni     (reset_reset_n),
    .sda_i      (i2c_serial_sda_in),
    .scl_i      (i2c_serial_scl_in),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise_s),
    .scl_fall_o (scl_fall_s),
    .start_o    (start_s),
    .stop_o     (stop_s)
  );

  state_e        state_q;
  logic [3:0]    bit_cnt_q;
  logic [6:0]    shift_q;    // received bits so far, or remaining read bits
  logic [AW-1:0] ptr_q;
  logic          rw_q;
  logic          sda_oe_q;
  logic          busy_q;
  logic          wr_strobe_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    regs_q [NUM_REGS];

  logic [7:0] byte_s;
  logic [7:0] rd_byte_s;
  logic       bus_we_s;

  assign byte_s      = {shift_q, sda_s};
  assign rd_byte_s   = regs_q[ptr_q];
  assign reg_rd_data = regs_q[reg_addr];
  // START/STOP take priority over bit events, so a write is only committed
  // when the FSM really consumes the 8th data bit.
  assign bus_we_s = (state_q == ST_WDATA) && scl_rise_s && (bit_cnt_q == 4'd7)
                    && !start_s && !stop_s;

  assign i2c_serial_sda_oe = sda_oe_q;
  assign i2c_serial_scl_oe = 1'b0;
  assign i2c_wr_strobe     = wr_strobe_q;
  assign i2c_wr_addr       = wr_addr_q;
  assign i2c_wr_data       = wr_data_q;
  assign busy              = busy_q;

  // Register bank; the local write is applied last so it wins a collision.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      if (bus_we_s) regs_q[ptr_q] <= byte_s;
      if (reg_wr_en) regs_q[reg_addr] <= reg_wr_data;
    end
  end

  // Protocol FSM with shifter, pointer and all registered bus-side outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 7'd0;
      ptr_q       <= '0;
      rw_q        <= RW_WRITE;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      wr_strobe_q <= 1'b0;
      if (stop_s) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= 4'd0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else if (start_s) begin
        state_q   <= ST_ADDR;
        bit_cnt_q <= 4'd0;
        sda_oe_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise_s) begin
              shift_q <= byte_s[6:0];
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                if (state_q == ST_ADDR) begin
                  if (byte_s[7:1] == TARGET_ADDR) begin
                    state_q <= ST_ADDR_ACK;
                    rw_q    <= byte_s[0];
                    busy_q  <= 1'b1;
                  end else begin
                    state_q <= ST_WAIT_STOP;
                    busy_q  <= 1'b0;
                  end
                end else if (state_q == ST_PTR) begin
                  ptr_q   <= byte_s[AW-1:0];
                  state_q <= ST_PTR_ACK;
                end else begin
                  wr_strobe_q <= 1'b1;
                  wr_addr_q   <= ptr_q;
                  wr_data_q   <= byte_s;
                  ptr_q       <= ptr_q + AW'(1);
                  state_q     <= ST_WDATA_ACK;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          // First falling edge drives ACK, second one (after 9th clock) ends it.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall_s) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                bit_cnt_q <= 4'd0;
                if ((state_q == ST_ADDR_ACK) && (rw_q == RW_READ)) begin
                  state_q  <= ST_RDATA;
                  shift_q  <= rd_byte_s[6:0];
                  sda_oe_q <= ~rd_byte_s[7];
                end else if (state_q == ST_ADDR_ACK) begin
                  state_q  <= ST_PTR;
                  sda_oe_q <= 1'b0;
                end else begin
                  state_q  <= ST_WDATA;
                  sda_oe_q <= 1'b0;
                end
              end
            end
          end
          // bit_cnt_q counts bits the initiator has sampled.
          ST_RDATA: begin
            if (scl_rise_s) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall_s) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_RDATA_ACK;
              end else begin
                sda_oe_q <= ~shift_q[6];
                shift_q  <= {shift_q[5:0], 1'b0};
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise_s) begin
              if (sda_s == ACK_BIT) begin
                ptr_q <= ptr_q + AW'(1);
              end else begin
                state_q <= ST_WAIT_STOP;
                busy_q  <= 1'b0;
              end
            end else if (scl_fall_s) begin
              state_q   <= ST_RDATA;
              bit_cnt_q <= 4'd0;
              shift_q   <= rd_byte_s[6:0];
              sda_oe_q  <= ~rd_byte_s[7];
            end
          end
          default: begin
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
